// File: rtl/accel_bus_pkg.sv
// rtl/accel_bus_pkg.sv - shared types and defaults for the accelerator bus bridge
package accel_bus_pkg;

  localparam int DATA_W_DEFAULT = 16;

  typedef enum logic {
    IDLE,
    RD_WAIT
  } rd_state_e;

endpackage

// File: rtl/bus_fifo.sv
// rtl/bus_fifo.sv - show-ahead FIFO with count-derived full/empty
module bus_fifo
  import accel_bus_pkg::*;
#(
  parameter int WIDTH = DATA_W_DEFAULT,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !rst) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

  a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/accel_bus_bridge.sv
// rtl/accel_bus_bridge.sv - CPU bus to NN accelerator bridge with TX/RX FIFOs and read FSM
module accel_bus_bridge
  import accel_bus_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEFAULT,
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cpu_wr_en,
  input  logic [DATA_W-1:0]          cpu_wr_data,
  input  logic                       cpu_rd_en,
  output logic [DATA_W-1:0]          cpu_rd_data,
  output logic                       cpu_rd_valid,
  output logic                       cpu_stall,
  output logic                       acc_tx_valid,
  input  logic                       acc_tx_ready,
  output logic [DATA_W-1:0]          acc_tx_data,
  input  logic                       acc_rx_valid,
  output logic                       acc_rx_ready,
  input  logic [DATA_W-1:0]          acc_rx_data,
  output logic [$clog2(TX_DEPTH):0]  tx_count,
  output logic [$clog2(RX_DEPTH):0]  rx_count
);

  rd_state_e         rd_state;
  logic              tx_full, tx_empty, tx_push, tx_pop;
  logic              rx_full, rx_empty, rx_push, rx_pop;
  logic [DATA_W-1:0] rx_head;
  logic              wr_done, rd_done;
  logic              wr_stall, rd_stall, rd_req;

  assign acc_tx_valid = !tx_empty;
  assign tx_pop       = acc_tx_valid && acc_tx_ready;
  assign tx_push      = cpu_wr_en && !wr_done && (!tx_full || acc_tx_ready);
  assign wr_stall     = cpu_wr_en && !wr_done && tx_full && !acc_tx_ready;

  assign acc_rx_ready = !rx_full;
  assign rx_push      = acc_rx_valid && acc_rx_ready;

  // RD_WAIT keeps the read pending even though the CPU request is only held, not re-issued.
  assign rd_req       = (rd_state == RD_WAIT) || (cpu_rd_en && !rd_done);
  assign rx_pop       = rd_req && !rx_empty;
  assign rd_stall     = rd_req && rx_empty;

  assign cpu_stall    = wr_stall || rd_stall;

  bus_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .wdata (cpu_wr_data),
    .pop   (tx_pop),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count),
    .head  (acc_tx_data)
  );

  bus_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .wdata (acc_rx_data),
    .pop   (rx_pop),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count),
    .head  (rx_head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state     <= IDLE;
      cpu_rd_data  <= '0;
      cpu_rd_valid <= 1'b0;
      wr_done      <= 1'b0;
      rd_done      <= 1'b0;
    end else begin
      cpu_rd_valid <= rx_pop;
      if (rx_pop) cpu_rd_data <= rx_head;
      case (rd_state)
        IDLE:    if (rd_stall) rd_state <= RD_WAIT;
        RD_WAIT: if (rx_pop)   rd_state <= IDLE;
        default: rd_state <= IDLE;
      endcase
      // A half serviced while the other stalls must not be replayed; cleared once the CPU moves on.
      wr_done <= cpu_stall && (wr_done || tx_push);
      rd_done <= cpu_stall && (rd_done || rx_pop);
    end
  end

endmodule

// File: tb/tb_accel_bus_bridge.sv
// tb/tb_accel_bus_bridge.sv - randomized and directed bench for accel_bus_bridge
module tb_accel_bus_bridge;

  localparam int DW    = 16;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_wr_en = 1'b0, cpu_rd_en = 1'b0;
  logic [DW-1:0] cpu_wr_data = '0, acc_rx_data = '0;
  logic          acc_tx_ready = 1'b0, acc_rx_valid = 1'b0;
  logic [DW-1:0] cpu_rd_data, acc_tx_data;
  logic          cpu_rd_valid, cpu_stall, acc_tx_valid, acc_rx_ready;
  logic [3:0]    tx_count, rx_count;

  int            n_chk = 0;
  int            n_fail = 0;
  int            rd_pulses = 0;
  logic [DW-1:0] tq[$];
  logic [DW-1:0] rq[$];
  logic [DW-1:0] dut_seen[$];
  logic [DW-1:0] m_rd_data;
  bit            m_rd_valid, m_wait, m_wr_done, m_rd_done, last_stall;
  bit            r_wr, r_rd;
  logic [DW-1:0] r_wd;

  always #5 clk = ~clk;

  accel_bus_bridge #(.DATA_W(DW), .TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_wr_en    (cpu_wr_en),
    .cpu_wr_data  (cpu_wr_data),
    .cpu_rd_en    (cpu_rd_en),
    .cpu_rd_data  (cpu_rd_data),
    .cpu_rd_valid (cpu_rd_valid),
    .cpu_stall    (cpu_stall),
    .acc_tx_valid (acc_tx_valid),
    .acc_tx_ready (acc_tx_ready),
    .acc_tx_data  (acc_tx_data),
    .acc_rx_valid (acc_rx_valid),
    .acc_rx_ready (acc_rx_ready),
    .acc_rx_data  (acc_rx_data),
    .tx_count     (tx_count),
    .rx_count     (rx_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    tq.delete();
    rq.delete();
    dut_seen.delete();
    m_rd_data  = '0;
    m_rd_valid = 1'b0;
    m_wait     = 1'b0;
    m_wr_done  = 1'b0;
    m_rd_done  = 1'b0;
    last_stall = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cpu_wr_en = 1'b0; cpu_rd_en = 1'b0; cpu_wr_data = '0;
    acc_tx_ready = 1'b0; acc_rx_valid = 1'b0; acc_rx_data = '0;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    #1;
  endtask

  // One bus cycle: drive, compare against the queue model, then advance the model.
  task automatic step(input bit wr, input logic [DW-1:0] wd, input bit rd,
                      input bit txr, input bit rxv, input logic [DW-1:0] rxd);
    bit want_wr, wr_ok, want_rd, rd_ok, stall, rx_take;
    @(negedge clk);
    cpu_wr_en = wr; cpu_wr_data = wd; cpu_rd_en = rd;
    acc_tx_ready = txr; acc_rx_valid = rxv; acc_rx_data = rxd;
    #1;
    want_wr = wr && !m_wr_done;
    wr_ok   = want_wr && (tq.size() < DEPTH || txr);
    want_rd = m_wait || (rd && !m_rd_done);
    rd_ok   = want_rd && (rq.size() > 0);
    stall   = (want_wr && !wr_ok) || (want_rd && !rd_ok);
    rx_take = rxv && (rq.size() < DEPTH);
    chk("cpu_stall",    32'(cpu_stall),    32'(stall));
    chk("acc_tx_valid", 32'(acc_tx_valid), 32'(tq.size() > 0));
    if (tq.size() > 0) chk("acc_tx_data", 32'(acc_tx_data), 32'(tq[0]));
    chk("acc_rx_ready", 32'(acc_rx_ready), 32'(rq.size() < DEPTH));
    chk("tx_count",     32'(tx_count),     32'(tq.size()));
    chk("rx_count",     32'(rx_count),     32'(rq.size()));
    chk("cpu_rd_valid", 32'(cpu_rd_valid), 32'(m_rd_valid));
    chk("cpu_rd_data",  32'(cpu_rd_data),  32'(m_rd_data));
    if (cpu_rd_valid) rd_pulses++;
    if (acc_tx_valid && txr) dut_seen.push_back(acc_tx_data);
    if (txr && tq.size() > 0) void'(tq.pop_front());
    if (wr_ok) tq.push_back(wd);
    m_rd_valid = rd_ok;
    if (rd_ok) m_rd_data = rq.pop_front();
    if (rx_take) rq.push_back(rxd);
    m_wait     = want_rd && !rd_ok;
    m_wr_done  = stall && (m_wr_done || wr_ok);
    m_rd_done  = stall && (m_rd_done || rd_ok);
    last_stall = stall;
  endtask

  initial begin
    do_reset();
    chk("reset_tx_count", 32'(tx_count), 0);
    chk("reset_rd_data",  32'(cpu_rd_data), 0);
    chk("reset_stall",    32'(cpu_stall), 0);

    // 1: reset with three words queued and a read result about to appear
    step(0, 16'h0, 0, 0, 1, 16'h0077);
    step(1, 16'h0101, 0, 0, 0, 16'h0);
    step(1, 16'h0202, 0, 0, 0, 16'h0);
    step(1, 16'h0303, 1, 0, 0, 16'h0);
    do_reset();
    chk("t1_tx_count",     32'(tx_count), 0);
    chk("t1_acc_tx_valid", 32'(acc_tx_valid), 0);
    chk("t1_acc_rx_ready", 32'(acc_rx_ready), 1);
    chk("t1_cpu_rd_valid", 32'(cpu_rd_valid), 0);
    chk("t1_rx_count",     32'(rx_count), 0);

    // 2: in-order delivery with a ready accelerator
    step(1, 16'h1111, 0, 1, 0, 16'h0);
    chk("t2_stall", 32'(cpu_stall), 0);
    step(1, 16'h2222, 0, 1, 0, 16'h0);
    chk("t2_stall", 32'(cpu_stall), 0);
    step(1, 16'h3333, 0, 1, 0, 16'h0);
    chk("t2_stall", 32'(cpu_stall), 0);
    step(0, 16'h0, 0, 1, 0, 16'h0);
    chk("t2_seen_n", 32'(dut_seen.size()), 3);
    if (dut_seen.size() == 3) begin
      chk("t2_seen0", 32'(dut_seen[0]), 32'h1111);
      chk("t2_seen1", 32'(dut_seen[1]), 32'h2222);
      chk("t2_seen2", 32'(dut_seen[2]), 32'h3333);
    end

    // 3: ninth write stalls on a full TX FIFO, then lands alongside a pop
    do_reset();
    for (int i = 1; i <= 8; i++) step(1, 16'(i), 0, 0, 0, 16'h0);
    step(1, 16'h0009, 0, 0, 0, 16'h0);
    chk("t3_full_stall", 32'(cpu_stall), 1);
    step(1, 16'h0009, 0, 1, 0, 16'h0);
    chk("t3_accept", 32'(cpu_stall), 0);
    step(0, 16'h0, 0, 0, 0, 16'h0);
    chk("t3_tx_count", 32'(tx_count), 8);
    for (int i = 0; i < 8; i++) step(0, 16'h0, 0, 1, 0, 16'h0);
    chk("t3_last_word", 32'(dut_seen[dut_seen.size()-1]), 32'h0009);

    // 4: read from empty RX waits for the accelerator result
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      step(0, 16'h0, 1, 0, 0, 16'h0);
      chk("t4_wait_stall", 32'(cpu_stall), 1);
    end
    step(0, 16'h0, 1, 0, 1, 16'hBEEF);
    chk("t4_c5_stall", 32'(cpu_stall), 1);
    step(0, 16'h0, 1, 0, 0, 16'h0);
    chk("t4_c6_stall", 32'(cpu_stall), 0);
    step(0, 16'h0, 0, 0, 0, 16'h0);
    chk("t4_c7_valid", 32'(cpu_rd_valid), 1);
    chk("t4_c7_data",  32'(cpu_rd_data), 32'hBEEF);

    // 5: full RX back-pressures the accelerator until a CPU read
    do_reset();
    for (int i = 0; i < 8; i++) step(0, 16'h0, 0, 0, 1, 16'(16'h0100 + i));
    step(0, 16'h0, 0, 0, 1, 16'hDEAD);
    chk("t5_rx_ready_full", 32'(acc_rx_ready), 0);
    step(0, 16'h0, 1, 0, 0, 16'h0);
    step(0, 16'h0, 0, 0, 0, 16'h0);
    chk("t5_rx_count", 32'(rx_count), 7);
    chk("t5_rx_ready", 32'(acc_rx_ready), 1);
    chk("t5_rd_data",  32'(cpu_rd_data), 32'h0100);

    // 6: combined access, read completes once while the write stalls
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 16'(16'h0600 + i), 0, 0, 0, 16'h0);
    step(0, 16'h0, 0, 0, 1, 16'h0042);
    rd_pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step(1, 16'hA5A5, 1, 0, 0, 16'h0);
      chk("t6_stall", 32'(cpu_stall), 1);
    end
    step(1, 16'hA5A5, 1, 1, 0, 16'h0);
    chk("t6_release", 32'(cpu_stall), 0);
    step(0, 16'h0, 0, 0, 0, 16'h0);
    step(0, 16'h0, 0, 0, 0, 16'h0);
    chk("t6_rd_pulses", 32'(rd_pulses), 1);
    chk("t6_rd_data",   32'(cpu_rd_data), 32'h0042);
    chk("t6_rx_count",  32'(rx_count), 0);

    // Randomized traffic; the CPU holds its request while stalled
    do_reset();
    r_wr = 1'b0; r_rd = 1'b0; r_wd = '0;
    for (int i = 0; i < 800; i++) begin
      bit txr, rxv;
      if (i == 400) do_reset();
      if (!last_stall) begin
        r_wr = ($urandom_range(0, 2) == 0);
        r_rd = ($urandom_range(0, 2) == 0);
        r_wd = 16'($urandom);
      end
      if ((i / 100) % 2 == 0) begin
        txr = ($urandom_range(0, 3) == 0);
        rxv = ($urandom_range(0, 3) != 0);
      end else begin
        txr = ($urandom_range(0, 3) != 0);
        rxv = ($urandom_range(0, 3) == 0);
      end
      step(r_wr, r_wd, r_rd, txr, rxv, 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
